// File: rtl/mem_arbiter.sv
// Two-master arbiter for the shared register-file/RAM port: combinational grant,
// round-robin on contention, optional bounded lock, and 1-cycle read-response routing.
module mem_arbiter #(
    parameter int W        = 32,
    parameter int AW       = 16,
    parameter int MAX_HOLD = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          m0_rd_en,
    input  logic          m0_wr_en,
    input  logic [AW-1:0] m0_addr,
    input  logic [W-1:0]  m0_wr_data,
    input  logic [3:0]    m0_wr_mask,
    input  logic          m0_lock,
    output logic          m0_ready,
    output logic [W-1:0]  m0_rd_data,
    output logic          m0_rd_valid,
    input  logic          m1_rd_en,
    input  logic          m1_wr_en,
    input  logic [AW-1:0] m1_addr,
    input  logic [W-1:0]  m1_wr_data,
    input  logic [3:0]    m1_wr_mask,
    input  logic          m1_lock,
    output logic          m1_ready,
    output logic [W-1:0]  m1_rd_data,
    output logic          m1_rd_valid,
    output logic          mem_rd_en,
    output logic          mem_wr_en,
    output logic [AW-1:0] mem_addr,
    output logic [W-1:0]  mem_wr_data,
    output logic [3:0]    mem_wr_mask,
    input  logic [W-1:0]  mem_rd_data,
    input  logic          mem_rd_valid,
    output logic [1:0]    owner
);

    localparam int HW = $clog2(MAX_HOLD);
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            rr_ptr_q, rr_ptr_d;
    logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
    logic            rsp_pend_q, rsp_pend_d;
    logic            rsp_id_q, rsp_id_d;

    logic            req0, req1;
    logic            gnt_raw, gnt_id, gnt_valid, gnt_lock, forced;
    logic            own_id, own_req, own_lock, other_req;
    logic            sel_rd, sel_wr;
    logic [AW-1:0]   sel_addr;
    logic [W-1:0]    sel_data;
    logic [3:0]      sel_mask;
    logic [1:0]      rd_valid_vec;

    assign req0 = m0_rd_en | m0_wr_en;
    assign req1 = m1_rd_en | m1_wr_en;

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        hold_cnt_d = hold_cnt_q;
        gnt_raw    = 1'b0;
        gnt_id     = 1'b0;
        forced     = 1'b0;
        own_id     = (state_q == OWN1);
        own_req    = own_id ? req1 : req0;
        own_lock   = own_id ? m1_lock : m0_lock;
        other_req  = own_id ? req0 : req1;

        case (state_q)
            IDLE: begin
                if (req0 && req1) begin
                    gnt_raw = 1'b1;
                    gnt_id  = rr_ptr_q;
                end else if (req0 || req1) begin
                    gnt_raw = 1'b1;
                    gnt_id  = req1;
                end
            end
            default: begin
                // Hold budget exhausted: the owner is refused so the other side wins next.
                if (hold_cnt_q == HOLD_LAST) begin
                    forced = 1'b1;
                end else if (own_req) begin
                    gnt_raw = 1'b1;
                    gnt_id  = own_id;
                end
            end
        endcase

        gnt_lock = gnt_id ? m1_lock : m0_lock;

        if (forced) begin
            state_d  = IDLE;
            rr_ptr_d = ~own_id;
        end else if (gnt_raw) begin
            if (gnt_lock) begin
                state_d = gnt_id ? OWN1 : OWN0;
            end else begin
                state_d  = IDLE;
                rr_ptr_d = ~gnt_id;
            end
        end else if (state_q != IDLE && !own_lock) begin
            state_d  = IDLE;
            rr_ptr_d = ~own_id;
        end

        if (state_d == IDLE) begin
            hold_cnt_d = '0;
        end else if (state_q != IDLE && other_req && hold_cnt_q != '1) begin
            hold_cnt_d = hold_cnt_q + HW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rr_ptr_q   <= 1'b0;
            hold_cnt_q <= '0;
            rsp_pend_q <= 1'b0;
            rsp_id_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            hold_cnt_q <= hold_cnt_d;
            rsp_pend_q <= rsp_pend_d;
            rsp_id_q   <= rsp_id_d;
        end
    end

    assign sel_rd   = gnt_id ? m1_rd_en   : m0_rd_en;
    assign sel_wr   = gnt_id ? m1_wr_en   : m0_wr_en;
    assign sel_addr = gnt_id ? m1_addr    : m0_addr;
    assign sel_data = gnt_id ? m1_wr_data : m0_wr_data;
    assign sel_mask = gnt_id ? m1_wr_mask : m0_wr_mask;

    // Outputs are forced quiet while reset is asserted, even if masters keep requesting.
    assign gnt_valid = gnt_raw & rst_n;

    // A simultaneous read+write forwards only the write.
    assign rsp_pend_d = gnt_raw & sel_rd & ~sel_wr;
    assign rsp_id_d   = gnt_id;

    assign m0_ready    = gnt_valid & ~gnt_id;
    assign m1_ready    = gnt_valid & gnt_id;
    assign mem_rd_en   = gnt_valid & sel_rd & ~sel_wr;
    assign mem_wr_en   = gnt_valid & sel_wr;
    assign mem_addr    = gnt_valid ? sel_addr : '0;
    assign mem_wr_data = gnt_valid ? sel_data : '0;
    assign mem_wr_mask = gnt_valid ? sel_mask : 4'b1111;
    assign owner       = {gnt_valid, gnt_valid & gnt_id};

    for (genvar gi = 0; gi < 2; gi++) begin : g_rsp
        assign rd_valid_vec[gi] = mem_rd_valid & rsp_pend_q & (rsp_id_q == 1'(gi));
    end

    assign m0_rd_valid = rd_valid_vec[0];
    assign m1_rd_valid = rd_valid_vec[1];
    assign m0_rd_data  = mem_rd_data;
    assign m1_rd_data  = mem_rd_data;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized checks of mem_arbiter against a behavioural model of
// grant, lock, hold-limit and response-routing rules.
module tb_mem_arbiter;

    localparam int W        = 32;
    localparam int AW       = 16;
    localparam int MAX_HOLD = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          rd_en [2];
    logic          wr_en [2];
    logic          lock  [2];
    logic [AW-1:0] addr  [2];
    logic [W-1:0]  wdata [2];
    logic [3:0]    mask  [2];
    logic          ready [2];
    logic          rd_valid [2];
    logic [W-1:0]  rd_data  [2];
    logic          mem_rd_en, mem_wr_en;
    logic [AW-1:0] mem_addr;
    logic [W-1:0]  mem_wr_data;
    logic [3:0]    mem_wr_mask;
    logic [W-1:0]  mem_rd_data;
    logic          mem_rd_valid;
    logic [1:0]    owner;

    // Memory stand-in: read data is a tag plus the address seen one cycle earlier.
    logic          mem_rv_q;
    logic [W-1:0]  mem_rd_q;
    logic          spur;

    int n_checks = 0;
    int n_fail   = 0;
    int step_no  = 0;

    int            m_holder, m_pref, m_contend, m_pend, m_pend_id, m_mem_rv;
    logic [AW-1:0] m_prev_addr;

    logic          obs_ready [2];
    logic          obs_rdv   [2];
    logic [1:0]    obs_owner;
    logic          obs_rd_en, obs_wr_en;
    logic [AW-1:0] obs_addr;
    logic [W-1:0]  obs_wdata;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        mem_rv_q <= mem_rd_en;
        mem_rd_q <= {16'hC3C3, mem_addr};
    end
    assign mem_rd_data  = mem_rd_q;
    assign mem_rd_valid = mem_rv_q | spur;

    mem_arbiter #(.W(W), .AW(AW), .MAX_HOLD(MAX_HOLD)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .m0_rd_en    (rd_en[0]),
        .m0_wr_en    (wr_en[0]),
        .m0_addr     (addr[0]),
        .m0_wr_data  (wdata[0]),
        .m0_wr_mask  (mask[0]),
        .m0_lock     (lock[0]),
        .m0_ready    (ready[0]),
        .m0_rd_data  (rd_data[0]),
        .m0_rd_valid (rd_valid[0]),
        .m1_rd_en    (rd_en[1]),
        .m1_wr_en    (wr_en[1]),
        .m1_addr     (addr[1]),
        .m1_wr_data  (wdata[1]),
        .m1_wr_mask  (mask[1]),
        .m1_lock     (lock[1]),
        .m1_ready    (ready[1]),
        .m1_rd_data  (rd_data[1]),
        .m1_rd_valid (rd_valid[1]),
        .mem_rd_en   (mem_rd_en),
        .mem_wr_en   (mem_wr_en),
        .mem_addr    (mem_addr),
        .mem_wr_data (mem_wr_data),
        .mem_wr_mask (mem_wr_mask),
        .mem_rd_data (mem_rd_data),
        .mem_rd_valid(mem_rd_valid),
        .owner       (owner)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s step %0d: observed %0h expected %0h", tag, step_no, obs, exp);
        end
    endtask

    task automatic set_m(input int n, input logic r, input logic w, input logic l,
                         input logic [AW-1:0] a, input logic [W-1:0] d, input logic [3:0] m);
        rd_en[n] = r; wr_en[n] = w; lock[n] = l;
        addr[n]  = a; wdata[n] = d; mask[n] = m;
    endtask

    task automatic idle_all();
        for (int n = 0; n < 2; n++) set_m(n, 1'b0, 1'b0, 1'b0, '0, '0, 4'h0);
    endtask

    // One clock cycle: predict, sample 1ns after the falling edge, advance the model.
    task automatic step();
        int            win;
        int            g;
        bit            forced;
        bit            req [2];
        logic          e_rd, e_wr;
        logic [AW-1:0] e_addr;
        logic [W-1:0]  e_data;
        logic [3:0]    e_mask;
        logic [1:0]    e_owner;
        logic          e_rdv [2];

        step_no++;
        for (int n = 0; n < 2; n++) req[n] = rd_en[n] | wr_en[n];
        if (!rst_n) begin
            m_holder = -1; m_pref = 0; m_contend = 0; m_pend = 0;
        end

        win = -1; forced = 0; g = m_holder;
        if (rst_n) begin
            if (m_holder < 0) begin
                if (req[0] && req[1]) win = m_pref;
                else if (req[0])      win = 0;
                else if (req[1])      win = 1;
            end else if (m_contend == MAX_HOLD - 1) begin
                forced = 1;
            end else if (req[g]) begin
                win = g;
            end
        end

        e_rd = 0; e_wr = 0; e_addr = '0; e_data = '0; e_mask = 4'hF; e_owner = 2'b00;
        if (win >= 0) begin
            e_wr    = wr_en[win];
            e_rd    = rd_en[win] & ~wr_en[win];
            e_addr  = addr[win];
            e_data  = wdata[win];
            e_mask  = mask[win];
            e_owner = {1'b1, win[0]};
        end
        for (int n = 0; n < 2; n++)
            e_rdv[n] = (m_mem_rv != 0 || spur) && m_pend != 0 && m_pend_id == n;

        #1;
        chk("ready0",  ready[0], (win == 0));
        chk("ready1",  ready[1], (win == 1));
        chk("rd_en",   mem_rd_en, e_rd);
        chk("wr_en",   mem_wr_en, e_wr);
        chk("addr",    mem_addr, e_addr);
        chk("wr_data", mem_wr_data, e_data);
        chk("wr_mask", mem_wr_mask, e_mask);
        chk("owner",   owner, e_owner);
        chk("rdv0",    rd_valid[0], e_rdv[0]);
        chk("rdv1",    rd_valid[1], e_rdv[1]);
        for (int n = 0; n < 2; n++)
            if (e_rdv[n]) chk("rd_data", rd_data[n], {16'hC3C3, m_prev_addr});

        obs_ready[0] = ready[0]; obs_ready[1] = ready[1];
        obs_rdv[0] = rd_valid[0]; obs_rdv[1] = rd_valid[1];
        obs_owner = owner; obs_rd_en = mem_rd_en; obs_wr_en = mem_wr_en;
        obs_addr = mem_addr; obs_wdata = mem_wr_data;

        @(posedge clk);
        m_mem_rv    = e_rd;
        m_prev_addr = e_addr;
        if (rst_n) begin
            m_pend    = e_rd;
            m_pend_id = win;
            if (forced) begin
                m_holder = -1; m_pref = 1 - g;
            end else if (win >= 0) begin
                if (lock[win]) m_holder = win;
                else begin m_holder = -1; m_pref = 1 - win; end
            end else if (g >= 0 && !lock[g]) begin
                m_holder = -1; m_pref = 1 - g;
            end
            if (m_holder < 0) m_contend = 0;
            else if (g >= 0 && req[1 - g] && m_contend < MAX_HOLD - 1) m_contend++;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_all();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; spur = 1'b0;
        idle_all();
        m_holder = -1; m_pref = 0; m_contend = 0; m_pend = 0; m_pend_id = 0;
        m_mem_rv = 0; m_prev_addr = '0;
        @(negedge clk);
        step();
        chk("reset_owner", obs_owner, 2'b00);
        chk("reset_addr",  obs_addr, 16'h0000);
        step();
        rst_n = 1'b1;

        // Single m0 read with m1 idle.
        set_m(0, 1'b1, 1'b0, 1'b0, 16'h0010, 32'h0, 4'hF);
        step();
        chk("t1_m0_ready", obs_ready[0], 1'b1);
        chk("t1_addr",     obs_addr, 16'h0010);
        idle_all();
        step();
        chk("t1_rdv0", obs_rdv[0], 1'b1);
        chk("t1_rdv1", obs_rdv[1], 1'b0);

        // Unlocked contention alternates starting with m0.
        do_reset();
        set_m(0, 1'b1, 1'b0, 1'b0, 16'h0100, 32'h0, 4'hF);
        set_m(1, 1'b1, 1'b0, 1'b0, 16'h0104, 32'h0, 4'hF);
        for (int i = 0; i < 6; i++) begin
            step();
            chk("t2_owner", obs_owner, (i % 2 == 0) ? 2'b10 : 2'b11);
        end

        // m0 locks for three beats while m1 waits.
        do_reset();
        set_m(1, 1'b1, 1'b0, 1'b0, 16'h0300, 32'h0, 4'hF);
        for (int i = 0; i < 3; i++) begin
            set_m(0, 1'b0, 1'b1, (i < 2), 16'h0020 + 16'(4 * i), 32'h1000 + 32'(i), 4'hF);
            step();
            chk("t3_m0_ready", obs_ready[0], 1'b1);
            chk("t3_m1_ready", obs_ready[1], 1'b0);
        end
        set_m(0, 1'b0, 1'b0, 1'b0, '0, '0, 4'h0);
        step();
        chk("t3_m1_grant", obs_ready[1], 1'b1);

        // m0 holds lock against a continuously requesting m1: hold limit kicks in.
        do_reset();
        set_m(0, 1'b1, 1'b0, 1'b1, 16'h0040, 32'h0, 4'hF);
        set_m(1, 1'b0, 1'b1, 1'b0, 16'h0400, 32'h5555AAAA, 4'hF);
        for (int i = 0; i < 6; i++) begin
            step();
            chk("t4_m0_ready", obs_ready[0], (i < 4));
            chk("t4_m1_ready", obs_ready[1], (i == 5));
        end

        // m1 read+write together: only the write goes out.
        do_reset();
        set_m(1, 1'b1, 1'b1, 1'b0, 16'h0200, 32'hDEADBEEF, 4'b0011);
        step();
        chk("t5_wr_en", obs_wr_en, 1'b1);
        chk("t5_rd_en", obs_rd_en, 1'b0);
        chk("t5_data",  obs_wdata, 32'hDEADBEEF);
        idle_all();
        step();
        chk("t5_rdv1", obs_rdv[1], 1'b0);

        // Reset right after an accepted read drops the response.
        do_reset();
        set_m(0, 1'b1, 1'b0, 1'b0, 16'h0044, 32'h0, 4'hF);
        step();
        rst_n = 1'b0;
        idle_all();
        set_m(1, 1'b1, 1'b0, 1'b0, 16'h0048, 32'h0, 4'hF);
        step();
        chk("t6_rdv0",   obs_rdv[0], 1'b0);
        chk("t6_ready1", obs_ready[1], 1'b0);
        chk("t6_owner",  obs_owner, 2'b00);
        step();
        rst_n = 1'b1;
        idle_all();

        // Stray memory valid with nothing outstanding.
        step();
        spur = 1'b1;
        step();
        chk("spur_rdv0", obs_rdv[0], 1'b0);
        chk("spur_rdv1", obs_rdv[1], 1'b0);
        spur = 1'b0;

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            for (int n = 0; n < 2; n++)
                set_m(n, ($urandom_range(2) == 0), ($urandom_range(3) == 0), ($urandom_range(1) == 0),
                      AW'($urandom), $urandom, 4'($urandom));
            spur = ($urandom_range(7) == 0);
            step();
        end
        spur = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
